// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: word width, FSM states
// and the {pc, word} entry carried through the prefetch FIFO.
package fetch_pkg;

  localparam int WORD_SIZE = 16;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    word_t pc;
    word_t word;
  } fetch_entry_t;

  // Sequential fetch address; wraps FFFF -> 0000 by width.
  function automatic word_t pc_next(input word_t pc);
    return pc + word_t'(1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the memory instruction port and the decode-side instruction port
// seen by fetch_unit (master) and by the memory/decode environment (slave).
interface fetch_if;
  import fetch_pkg::*;

  // Memory side: a read issued with i_readM=1 returns i_data one cycle later,
  // and i_readM stays high during that response cycle.
  logic  i_readM;
  logic  i_writeM;
  word_t i_address;
  word_t i_data;

  // Decode side: an instruction transfers on a cycle where inst_valid and
  // inst_ready are both high; inst/inst_pc are stable while inst_valid waits.
  // redirect_valid overrides any transfer in the same cycle.
  logic  inst_valid;
  word_t inst;
  word_t inst_pc;
  logic  inst_ready;
  logic  redirect_valid;
  word_t redirect_pc;

  modport master (
    output i_readM, i_writeM, i_address, inst_valid, inst, inst_pc,
    input  i_data, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  i_readM, i_writeM, i_address, inst_valid, inst, inst_pc,
    output i_data, inst_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH-entry circular buffer of {pc, word} with wrapping
// pointers, an occupancy count and a flush that empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               push_data,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    last_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Remembers the last presented head so the outputs hold steady once empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
    end else if (!empty) begin
      last_q <= mem_q[rd_ptr_q];
    end
  end

  assign head = empty ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: pipelined word reads into a prefetch FIFO,
// redirect flush, decode handshake. Optional counters under FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         reset_n,
  fetch_if.master      bus,
  output fetch_state_e dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]  perf_fetched,
  output logic [15:0]  perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  word_t         fetch_pc_q;
  word_t         inflight_pc_q;
  logic          inflight_q;
  logic          fetching;
  logic          issue;
  logic          push;
  logic          pop;
  logic          flush;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Idle for one cycle after reset so memory can finish loading its image.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: issue = !bus.redirect_valid &&
                       ((count + CW'(inflight_q)) < CW'(DEPTH));
      default: state_d = S_IDLE;
    endcase
  end

  assign fetching = (state_q == S_FETCH);
  assign flush    = fetching && bus.redirect_valid;
  assign push     = inflight_q && !bus.redirect_valid;
  assign pop      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

  // Counting the in-flight read against free slots guarantees the response
  // always finds room, so no push is ever refused.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (fetching) begin
      if (bus.redirect_valid) begin
        fetch_pc_q <= bus.redirect_pc;
        inflight_q <= 1'b0;
      end else if (issue) begin
        inflight_q    <= 1'b1;
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= pc_next(fetch_pc_q);
      end else begin
        inflight_q <= 1'b0;
      end
    end
  end

  assign push_entry = '{pc: inflight_pc_q, word: bus.i_data};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .push_data(push_entry),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

  // Memory keeps driving i_data only while i_readM is high, hence the OR.
  assign bus.i_readM    = issue | inflight_q;
  assign bus.i_writeM   = 1'b0;
  assign bus.i_address  = fetch_pc_q;
  assign bus.inst_valid = !empty;
  assign bus.inst       = head.word;
  assign bus.inst_pc    = head.pc;
  assign dbg_state      = state_q;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && (perf_fetched != 16'hFFFF)) begin
        perf_fetched <= perf_fetched + 16'd1;
      end
      if (fetching && empty && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model, stream-order reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int    DEPTH    = 4;
  localparam word_t RESET_PC = 16'h0000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  fetch_state_e dbg_state;
  fetch_if      bus ();
`ifdef FETCH_PERF_EN
  logic [15:0]  perf_fetched;
  logic [15:0]  perf_stall;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .dbg_state(dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- memory: registered read, drives only while i_readM ----
  logic [15:0] mem [65536];
  logic [15:0] mem_q;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    mem[0] = 16'h9023;
    mem[1] = 16'h0001;
    mem[2] = 16'hFFFF;
  end

  always @(posedge clk) begin
    if (bus.i_readM) mem_q <= mem[bus.i_address];
  end

  assign bus.i_data = bus.i_readM ? mem_q : 16'hDEAD;

  // ---------------- scoreboard helpers -----------------------------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!bus.inst_valid && n < max_cycles) begin
      tick(1);
      n++;
    end
    check({name, "_wait"}, 16'(bus.inst_valid), 16'h0001);
  endtask

  // ---------------- reference model --------------------------------------
  // Decode must see addresses in program order from the latest fetch target,
  // each with its memory word; when nothing is valid the last head is held.
  logic [15:0] exp_pc;
  logic [15:0] last_pc;
  logic [15:0] last_word;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_pc    <= RESET_PC;
      last_pc   <= 16'h0000;
      last_word <= 16'h0000;
    end else begin
      check("model_writeM", 16'(bus.i_writeM), 16'h0000);
      if (bus.inst_valid) begin
        check("model_pc", bus.inst_pc, exp_pc);
        check("model_inst", bus.inst, mem[exp_pc]);
        last_pc   <= exp_pc;
        last_word <= mem[exp_pc];
      end else begin
        check("model_hold_pc", bus.inst_pc, last_pc);
        check("model_hold_inst", bus.inst, last_word);
      end
      if (bus.redirect_valid) begin
        exp_pc <= bus.redirect_pc;
      end else if (bus.inst_valid && bus.inst_ready) begin
        exp_pc <= exp_pc + 16'h0001;
      end
    end
  end

  // ---------------- directed scenarios -----------------------------------
  logic [15:0] wrap_pc   [3];
  logic [15:0] wrap_word [3];

  initial begin
    wrap_pc   = '{16'hFFFE, 16'hFFFF, 16'h0000};
    wrap_word = '{16'h5A5B, 16'h5A5A, 16'h9023};
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    reset_n            = 1'b0;
    tick(2);

    // Reset values
    check("rst_readM", 16'(bus.i_readM), 16'h0000);
    check("rst_writeM", 16'(bus.i_writeM), 16'h0000);
    check("rst_address", bus.i_address, 16'h0000);
    check("rst_valid", 16'(bus.inst_valid), 16'h0000);
    check("rst_inst", bus.inst, 16'h0000);
    check("rst_inst_pc", bus.inst_pc, 16'h0000);
    check("rst_state", 16'(dbg_state), 16'(S_IDLE));

    // 1: startup stream
    reset_n = 1'b1;
    #1;
    check("t1_idle_readM", 16'(bus.i_readM), 16'h0000);
    tick(1);
    check("t1_readM_rise", 16'(bus.i_readM), 16'h0001);
    check("t1_first_addr", bus.i_address, 16'h0000);
    check("t1_state", 16'(dbg_state), 16'(S_FETCH));
    tick(1);
    check("t1_no_valid_yet", 16'(bus.inst_valid), 16'h0000);
    tick(1);
    check("t1_v0", 16'(bus.inst_valid), 16'h0001);
    check("t1_pc0", bus.inst_pc, 16'h0000);
    check("t1_w0", bus.inst, 16'h9023);
    tick(1);
    check("t1_v1", 16'(bus.inst_valid), 16'h0001);
    check("t1_pc1", bus.inst_pc, 16'h0001);
    check("t1_w1", bus.inst, 16'h0001);
    tick(1);
    check("t1_v2", 16'(bus.inst_valid), 16'h0001);
    check("t1_pc2", bus.inst_pc, 16'h0002);
    check("t1_w2", bus.inst, 16'hFFFF);

    // 2: decode stalls; FIFO fills to DEPTH and fetching stops
    bus.inst_ready = 1'b0;
    tick(10);
    check("t2_readM_low", 16'(bus.i_readM), 16'h0000);
    check("t2_head_pc", bus.inst_pc, 16'h0002);
    check("t2_four_buffered", bus.i_address, 16'h0006);
    bus.inst_ready = 1'b1;
    tick(8);

    // 3: redirect with a read in flight and a nearly full FIFO
    bus.inst_ready = 1'b0;
    tick(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0023;
    tick(1);
    bus.redirect_valid = 1'b0;
    check("t3_flushed", 16'(bus.inst_valid), 16'h0000);
    bus.inst_ready = 1'b1;
    wait_valid("t3", 6);
    check("t3_pc", bus.inst_pc, 16'h0023);
    check("t3_inst", bus.inst, 16'hA586);

    // 4: back-to-back redirects, last one wins, and the PC wraps
    tick(2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0100;
    tick(1);
    bus.redirect_pc    = 16'hFFFE;
    tick(1);
    bus.redirect_valid = 1'b0;
    check("t4_flushed", 16'(bus.inst_valid), 16'h0000);
    wait_valid("t4", 6);
    for (int i = 0; i < 3; i++) begin
      check("t4_valid", 16'(bus.inst_valid), 16'h0001);
      check("t4_wrap_pc", bus.inst_pc, wrap_pc[i]);
      check("t4_wrap_inst", bus.inst, wrap_word[i]);
      tick(1);
    end

    // 5: one-cycle reset mid-stream clears outputs at once
    tick(3);
    reset_n = 1'b0;
    #1;
    check("t5_readM", 16'(bus.i_readM), 16'h0000);
    check("t5_valid", 16'(bus.inst_valid), 16'h0000);
    check("t5_inst", bus.inst, 16'h0000);
    check("t5_inst_pc", bus.inst_pc, 16'h0000);
    check("t5_address", bus.i_address, 16'h0000);
    tick(1);
    reset_n = 1'b1;
    wait_valid("t5", 8);
    check("t5_restart_pc", bus.inst_pc, 16'h0000);
    check("t5_restart_inst", bus.inst, 16'h9023);

`ifdef FETCH_PERF_EN
    // 6: 20 fetch cycles with a double redirect: 5 empty cycles, 16 pushes
    tick(2);
    reset_n = 1'b0;
    #1;
    check("t6_rst_fetched", perf_fetched, 16'h0000);
    check("t6_rst_stall", perf_stall, 16'h0000);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    for (int k = 1; k <= 20; k++) begin
      bus.redirect_valid = (k == 8) || (k == 9);
      bus.redirect_pc    = (k == 8) ? 16'h0040 : 16'h0050;
      tick(1);
    end
    bus.redirect_valid = 1'b0;
    check("t6_perf_fetched", perf_fetched, 16'd16);
    check("t6_perf_stall", perf_stall, 16'd5);
`endif

    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, run %0d failed %0d", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
